// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Merges NUM_CH memory requesters (cache refill, dcache, MMU walkers) onto a
//   single downstream request port. Only one transaction is in flight at a time.
//   Channels are granted by fixed priority (ARB_MODE=0, channel 0 highest) or by
//   round-robin (ARB_MODE=1). The response is routed back only to the channel
//   that was granted.
//
// Ports
//   clk, rstn                   clock, asynchronous active-low reset
//   req_valid/req_ready         per-channel request handshake; req_ready is a
//                               one-hot (or zero) accept pulse in IDLE
//   req_wen/addr/wdata/wmask    per-channel request fields, packed by channel
//   resp_valid                  per-channel one-cycle response pulse
//   resp_rdata/resp_err         shared response bus; holds its last value
//   mem_valid/mem_ready         downstream request handshake
//   mem_wen/addr/wdata/wmask    latched request fields of the granted channel
//   mem_resp_valid/ready        downstream response handshake
//   mem_rdata/mem_resp_err      downstream response payload
module mem_port_arbiter #(
  parameter int NUM_CH     = 4,
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 128,
  parameter int ARB_MODE   = 1
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic [NUM_CH-1:0]              req_valid,
  output logic [NUM_CH-1:0]              req_ready,
  input  logic [NUM_CH-1:0]              req_wen,
  input  logic [NUM_CH*ADDR_WIDTH-1:0]   req_addr,
  input  logic [NUM_CH*DATA_WIDTH-1:0]   req_wdata,
  input  logic [NUM_CH*DATA_WIDTH/8-1:0] req_wmask,
  output logic [NUM_CH-1:0]              resp_valid,
  output logic [DATA_WIDTH-1:0]          resp_rdata,
  output logic                           resp_err,
  output logic                           mem_valid,
  input  logic                           mem_ready,
  output logic                           mem_wen,
  output logic [ADDR_WIDTH-1:0]          mem_addr,
  output logic [DATA_WIDTH-1:0]          mem_wdata,
  output logic [DATA_WIDTH/8-1:0]        mem_wmask,
  input  logic                           mem_resp_valid,
  output logic                           mem_resp_ready,
  input  logic [DATA_WIDTH-1:0]          mem_rdata,
  input  logic                           mem_resp_err
);

  localparam int PW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int MW = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  state_e                  state_q, state_d;
  logic [PW-1:0]           rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]           grant_q, grant_d;
  logic                    wen_q, wen_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [MW-1:0]           wmask_q, wmask_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    err_q, err_d;

  logic [PW-1:0]           base_s;
  logic [PW-1:0]           grant_s;
  logic                    any_req_s;

  // Search origin: rotating pointer in round-robin, channel 0 in fixed priority
  assign base_s    = (ARB_MODE == 1) ? rr_ptr_q : {PW{1'b0}};
  assign any_req_s = |req_valid;

  // Grant selection: first asserted channel starting at base_s, wrapping mod NUM_CH
  always_comb begin
    logic [PW:0]   sum;
    logic [PW-1:0] idx;
    logic [PW-1:0] g;
    logic          found;
    logic          hit;
    sum   = {(PW+1){1'b0}};
    idx   = {PW{1'b0}};
    g     = {PW{1'b0}};
    found = 1'b0;
    hit   = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      sum   = {1'b0, base_s} + (PW+1)'(k);
      idx   = (sum >= (PW+1)'(NUM_CH)) ? PW'(sum - (PW+1)'(NUM_CH)) : sum[PW-1:0];
      hit   = !found && req_valid[idx];
      g     = hit ? idx : g;
      found = found | hit;
    end
    grant_s = g;
  end

  // FSM state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic; a response seen while still in ISSUE is not accepted
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  state_d = any_req_s ? ST_ISSUE : ST_IDLE;
      ST_ISSUE: state_d = mem_ready ? ST_WAIT : ST_ISSUE;
      ST_WAIT:  state_d = mem_resp_valid ? ST_RESP : ST_WAIT;
      ST_RESP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: handshakes are decoded from the state register
  always_comb begin
    req_ready      = {NUM_CH{1'b0}};
    resp_valid     = {NUM_CH{1'b0}};
    mem_valid      = 1'b0;
    mem_resp_ready = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (any_req_s) begin
          req_ready[grant_s] = 1'b1;
        end else begin
          req_ready = {NUM_CH{1'b0}};
        end
      end
      ST_ISSUE: mem_valid          = 1'b1;
      ST_WAIT:  mem_resp_ready     = 1'b1;
      ST_RESP:  resp_valid[grant_q] = 1'b1;
      default: begin
        req_ready  = {NUM_CH{1'b0}};
        resp_valid = {NUM_CH{1'b0}};
      end
    endcase
  end

  // Datapath next values: capture the granted request, then the downstream response
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    wen_d    = wen_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wmask_d  = wmask_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (any_req_s) begin
          grant_d = grant_s;
          for (int i = 0; i < NUM_CH; i++) begin
            wen_d   = (grant_s == PW'(i)) ? req_wen[i] : wen_d;
            addr_d  = (grant_s == PW'(i)) ? req_addr[i*ADDR_WIDTH +: ADDR_WIDTH] : addr_d;
            wdata_d = (grant_s == PW'(i)) ? req_wdata[i*DATA_WIDTH +: DATA_WIDTH] : wdata_d;
            wmask_d = (grant_s == PW'(i)) ? req_wmask[i*MW +: MW] : wmask_d;
          end
          if (ARB_MODE == 1) begin
            rr_ptr_d = (grant_s == PW'(NUM_CH-1)) ? {PW{1'b0}} : grant_s + PW'(1);
          end else begin
            rr_ptr_d = rr_ptr_q;
          end
        end else begin
          grant_d = grant_q;
        end
      end
      ST_WAIT: begin
        if (mem_resp_valid) begin
          // Writes return no data; keep the shared bus clean for them
          rdata_d = wen_q ? {DATA_WIDTH{1'b0}} : mem_rdata;
          err_d   = mem_resp_err;
        end else begin
          rdata_d = rdata_q;
        end
      end
      default: begin
        rdata_d = rdata_q;
      end
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rr_ptr_q <= {PW{1'b0}};
      grant_q  <= {PW{1'b0}};
      wen_q    <= 1'b0;
      addr_q   <= {ADDR_WIDTH{1'b0}};
      wdata_q  <= {DATA_WIDTH{1'b0}};
      wmask_q  <= {MW{1'b0}};
      rdata_q  <= {DATA_WIDTH{1'b0}};
      err_q    <= 1'b0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      wen_q    <= wen_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wmask_q  <= wmask_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  assign mem_wen    = wen_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign mem_wmask  = wmask_q;
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule
